// File: rtl/posedge_pulse_detector_pkg.sv
// Shared constants for the rising-edge pulse detector and its input synchronizer.
package posedge_pulse_detector_pkg;

  // Legal range for the number of synchronizer flops in front of the edge detector.
  localparam int SYNC_STAGES_MIN = 0;
  localparam int SYNC_STAGES_MAX = 3;

  // True when a requested synchronizer depth can be built.
  function automatic bit sync_stages_legal(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/posedge_pulse_detector_sync.sv
// edge_sync_chain: N-flop synchronizer with asynchronous active-high reset.
// N=0 degenerates to a plain wire for inputs already synchronous to clk.
module edge_sync_chain
  import posedge_pulse_detector_pkg::*;
#(
  parameter int N = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (N == 0) begin : g_wire
    assign q = d;
  end else begin : g_flops
    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    // Shift the sampled input one stage deeper each clock; stage 0 takes d.
    always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = d;
    end

    // Synchronizer flops; cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end

    assign q = sync_q[N-1];
  end

  if (N > SYNC_STAGES_MAX) begin : g_depth_check
    $error("edge_sync_chain: N exceeds supported synchronizer depth");
  end

endmodule

// File: rtl/posedge_pulse_detector.sv
// posedge_pulse_detector: turns each sampled 0->1 transition of ip into a
// one-cycle registered pulse on out. Optional synchronizer for async inputs.
module posedge_pulse_detector
  import posedge_pulse_detector_pkg::*;
#(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic ip,
  output logic out
);

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_param_check
    $error("posedge_pulse_detector: SYNC_STAGES must be in 0..3");
  end

  logic ip_s;
  logic prev_q;
  logic prev_d;
  logic out_q;
  logic out_d;

  edge_sync_chain #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ip),
    .q   (ip_s)
  );

  // History follows the synchronized input; a pulse needs high now and low last sample.
  always_comb begin
    prev_d = ip_s;
    out_d  = ip_s & ~prev_q;
  end

  // History and output flops; reset clears both at once, so a pulse is never resumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      out_q  <= out_d;
    end
  end

  // Output comes straight from a flop: no combinational path from ip.
  assign out = out_q;

endmodule

// File: tb/tb_posedge_pulse_detector.sv
// Bench for posedge_pulse_detector: one instance without and one with a
// 2-stage synchronizer, both driven by the same ip/rst and checked against a
// sample-history model.
module tb_posedge_pulse_detector;

  logic clk;
  logic rst;
  logic ip;
  logic out0;
  logic out2;

  int errors = 0;
  int checks = 0;

  // History of ip values sampled at rising clk edges with rst low, newest first.
  // Reset refills it with zeros, matching prev and the synchronizer clearing.
  logic hist[$];

  posedge_pulse_detector #(.SYNC_STAGES(0)) dut0 (
    .clk (clk), .rst (rst), .ip (ip), .out (out0)
  );

  posedge_pulse_detector #(.SYNC_STAGES(2)) dut2 (
    .clk (clk), .rst (rst), .ip (ip), .out (out2)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 6; i++) hist.push_back(1'b0);
  endfunction

  function automatic void model_push(input logic v);
    hist.push_front(v);
    if (hist.size() > 6) void'(hist.pop_back());
  endfunction

  // Pulse after the latest edge for an n-stage synchronizer: the sample that
  // reaches the detector now is high and the one before it was low.
  function automatic logic model_out(input int n);
    return hist[n] & ~hist[n+1];
  endfunction

  // Drive ip, take one rising edge, record the sample, settle 1 ns past the edge.
  task automatic advance(input logic v);
    ip = v;
    @(posedge clk);
    if (!rst) model_push(v);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ip  = 1'b0;
    model_reset();
    #1;
    checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL reset_out0: got %0b expected 0", out0); end
    checks++; if (out2 !== 1'b0) begin errors++; $display("FAIL reset_out2: got %0b expected 0", out2); end
    #4 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      advance(1'b0);
      checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL idle_out0[%0d]: got %0b expected 0", i, out0); end
      checks++; if (out2 !== 1'b0) begin errors++; $display("FAIL idle_out2[%0d]: got %0b expected 0", i, out2); end
    end
  endtask

  task automatic test_single_edge();
    logic exp0 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic exp2 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic v    [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      advance(v[i]);
      checks++; if (out0 !== exp0[i]) begin errors++; $display("FAIL single_out0[%0d]: got %0b expected %0b", i, out0, exp0[i]); end
      checks++; if (out2 !== exp2[i]) begin errors++; $display("FAIL single_out2[%0d]: got %0b expected %0b", i, out2, exp2[i]); end
    end
  endtask

  task automatic test_held_level();
    int p0 = 0;
    int p2 = 0;
    for (int i = 0; i < 10; i++) begin
      advance((i < 6) ? 1'b1 : 1'b0);
      if (out0 === 1'b1) p0++;
      if (out2 === 1'b1) p2++;
      checks++; if (out0 !== model_out(0)) begin errors++; $display("FAIL held_out0[%0d]: got %0b expected %0b", i, out0, model_out(0)); end
    end
    checks++; if (p0 !== 1) begin errors++; $display("FAIL held_pulses0: got %0d expected 1", p0); end
    checks++; if (p2 !== 1) begin errors++; $display("FAIL held_pulses2: got %0d expected 1", p2); end
  endtask

  task automatic test_back_to_back();
    logic v    [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic exp0 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int p2 = 0;
    for (int i = 0; i < 5; i++) begin
      advance(v[i]);
      if (out2 === 1'b1) p2++;
      checks++; if (out0 !== exp0[i]) begin errors++; $display("FAIL b2b_out0[%0d]: got %0b expected %0b", i, out0, exp0[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      advance(1'b0);
      if (out2 === 1'b1) p2++;
    end
    checks++; if (p2 !== 2) begin errors++; $display("FAIL b2b_pulses2: got %0d expected 2", p2); end
  endtask

  task automatic test_glitch();
    advance(1'b0);
    #2 ip = 1'b1;
    #2 ip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      advance(1'b0);
      checks++; if ((out0 | out2) !== 1'b0) begin errors++; $display("FAIL glitch[%0d]: got out0=%0b out2=%0b expected 0 0", i, out0, out2); end
    end
  endtask

  task automatic test_reset_release_high();
    logic exp0 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic exp2 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    rst = 1'b1;
    ip  = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++; if ((out0 | out2) !== 1'b0) begin errors++; $display("FAIL rst_high_hold: got out0=%0b out2=%0b expected 0 0", out0, out2); end
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      advance(1'b1);
      checks++; if (out0 !== exp0[i]) begin errors++; $display("FAIL rel_out0[%0d]: got %0b expected %0b", i, out0, exp0[i]); end
      checks++; if (out2 !== exp2[i]) begin errors++; $display("FAIL rel_out2[%0d]: got %0b expected %0b", i, out2, exp2[i]); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    advance(1'b0);
    advance(1'b0);
    advance(1'b1);
    checks++; if (out0 !== 1'b1) begin errors++; $display("FAIL mid_pulse_pre: got %0b expected 1", out0); end
    #1 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL mid_pulse_async_clear: got %0b expected 0", out0); end
    ip = 1'b0;
    @(posedge clk); #1;
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      advance(1'b0);
      checks++; if ((out0 | out2) !== 1'b0) begin errors++; $display("FAIL mid_pulse_no_resume[%0d]: got out0=%0b out2=%0b expected 0 0", i, out0, out2); end
    end
  endtask

  task automatic test_random();
    int p0 = 0;
    int m0 = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        model_reset();
        #2;
        checks++; if ((out0 | out2) !== 1'b0) begin errors++; $display("FAIL rand_rst[%0d]: got out0=%0b out2=%0b expected 0 0", i, out0, out2); end
        rst = 1'b0;
      end
      advance(logic'($urandom_range(0, 1)));
      if (out0 === 1'b1) p0++;
      if (model_out(0)) m0++;
      checks++; if (out0 !== model_out(0)) begin errors++; $display("FAIL rand_out0[%0d]: got %0b expected %0b", i, out0, model_out(0)); end
      checks++; if (out2 !== model_out(2)) begin errors++; $display("FAIL rand_out2[%0d]: got %0b expected %0b", i, out2, model_out(2)); end
    end
    checks++; if (p0 !== m0) begin errors++; $display("FAIL rand_pulse_count0: got %0d expected %0d", p0, m0); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_held_level();
    test_back_to_back();
    test_glitch();
    test_reset_release_high();
    test_reset_mid_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
